// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, index width helper and counter width for the FIFO write arbiter
package fifo_arb_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, ACK, RETRY} state_t;
    localparam int RETRY_CNT_W = 16;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/grant bus plus FIFO write-side signals
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int FIFO_WIDTH = 16
);
    import fifo_arb_pkg::*;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0] gnt;
    logic [FIFO_WIDTH-1:0] fifo_data_in;
    logic fifo_wr_en;
    logic fifo_full;
    logic fifo_almostfull;
    logic fifo_wr_ack;
    logic fifo_overflow;
    logic busy;
    logic [RETRY_CNT_W-1:0] retry_cnt;
    modport master (
        input req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output gnt, fifo_data_in, fifo_wr_en, busy, retry_cnt
    );
    modport slave (
        output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input gnt, fifo_data_in, fifo_wr_en, busy, retry_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting just after rr_ptr, wrapping modulo NUM_REQ
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      winner,
    output logic               found
);
    logic [IW-1:0] idx;
    // walk from farthest to nearest so the nearest set request wins
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            winner = req[idx] ? idx : winner;
            found = found | req[idx];
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port with burst limit and overflow retry
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST = 4
) (
    input logic clk,
    input logic rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = idx_w(NUM_REQ);
    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, owner, pick, cap_idx;
    logic [3:0] burst_cnt;
    logic found, idle_grant, burst_cont, release_gnt, retry_hit, capture;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req(bus.req),
        .rr_ptr(rr_ptr),
        .winner(pick),
        .found(found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= IW'(NUM_REQ - 1);
            owner <= '0;
            burst_cnt <= '0;
            bus.gnt <= '0;
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_data_in <= '0;
            bus.busy <= 1'b0;
            bus.retry_cnt <= '0;
        end else begin
            state <= state_nx;
            bus.gnt <= capture ? (NUM_REQ'(1) << cap_idx) : '0;
            bus.fifo_data_in <= capture ? bus.req_data[int'(cap_idx)*FIFO_WIDTH +: FIFO_WIDTH] : bus.fifo_data_in;
            bus.fifo_wr_en <= state_nx == WRITE;
            bus.busy <= state_nx != IDLE;
            bus.retry_cnt <= (retry_hit && bus.retry_cnt != '1) ? bus.retry_cnt + 1'b1 : bus.retry_cnt;
            owner <= capture ? cap_idx : owner;
            burst_cnt <= idle_grant ? 4'd1 : burst_cont ? burst_cnt + 4'd1 : burst_cnt;
            rr_ptr <= release_gnt ? owner : rr_ptr;
        end
    end

    // a missing ack is handled like an overflow so the held word is never dropped
    always_comb begin
        state_nx = (state == IDLE)  ? (idle_grant ? WRITE : IDLE) :
                   (state == WRITE) ? ACK :
                   (state == ACK)   ? (bus.fifo_wr_ack ? (burst_cont ? WRITE : IDLE) : RETRY) :
                   (bus.fifo_full ? RETRY : WRITE);
    end

    always_comb begin
        idle_grant = state == IDLE && found && !bus.fifo_full;
        burst_cont = state == ACK && bus.fifo_wr_ack && bus.req[owner] && burst_cnt < 4'(MAX_BURST)
                     && !bus.fifo_almostfull && !bus.fifo_full;
        release_gnt = state == ACK && bus.fifo_wr_ack && !burst_cont;
        retry_hit = state == ACK && !bus.fifo_wr_ack;
        capture = idle_grant || burst_cont;
        cap_idx = idle_grant ? pick : owner;
    end
endmodule
